vid_mem_arbiter: RTL and testbench
==================================

# vid_mem_arbiter

Arbiter and sequencer for the single-port 32-bit video/main SRAM. Two requesters share it: the CPU data port and the display refill fetch. Display refill issues one word request per 32 pixels and has a hard deadline, so it always has priority. The block owns the SRAM control timing, latches refill requests, stalls the CPU with a request/acknowledge handshake, and flags lost refill requests. It sits between the display controller, the CPU bus and the SRAM pads.

## Interface
Parameters:
- ADR_W, 18: word address width.
- DATA_W, 32: data width.
- ACC_CYC, 2: SRAM access length in clock cycles. Minimum 2.

Ports:
- clk  in  1: system clock; all logic on the rising edge.
- rst  in  1: synchronous reset, active-high.
- cpu_req  in  1: CPU access request. Level signal; held with address and data until cpu_ack.
- cpu_we  in  1: 1 = write, 0 = read.
- cpu_adr  in  ADR_W: CPU word address.
- cpu_wdata  in  DATA_W: CPU write data.
- cpu_be  in  4: byte enables for writes.
- cpu_ack  out  1: one-cycle completion pulse.
- cpu_rdata  out  DATA_W: read data, valid while cpu_ack = 1.
- vid_req  in  1: one-cycle refill pulse, already synchronous to clk.
- vid_adr  in  ADR_W: refill address, sampled with vid_req.
- vid_valid  out  1: one-cycle pulse marking refill data.
- vid_data  out  DATA_W: refill word, valid while vid_valid = 1.
- vid_ovf  out  1: sticky refill-overrun flag.
- sram_adr  out  ADR_W: SRAM address.
- sram_wdata  out  DATA_W: SRAM write data.
- sram_oe_d  out  1: drive enable for the data pads.
- sram_we  out  1: write strobe, active-high.
- sram_be  out  4: byte enables.
- sram_rdata  in  DATA_W: SRAM read data.

## Operation
States:
- IDLE
- ACC: access in progress; cycle counter runs 0..ACC_CYC-1.
- DONE: completion cycle.

Arbitration happens in IDLE and in DONE:
- If vid_req or vid_pend is high, start a video read. vid_adr is latched, or the pending address is used.
- Otherwise, if cpu_req is high, start a CPU access. Exception: in the DONE cycle that completes a CPU access, cpu_req is ignored so the same request cannot be granted twice.
- If neither applies, go to IDLE.

Pending refill and overrun:
- vid_pend is set on a vid_req that is not granted in the same cycle.
- vid_pend is cleared when the video access is granted.
- A vid_req that arrives while vid_pend = 1 sets vid_ovf. The new address replaces the pending one.

SRAM signals during ACC:
- sram_adr and sram_be are registered from the granted request and held for the whole access.
- Write: sram_oe_d = 1 for all cycles. sram_we = 1 in cycles 0..ACC_CYC-2 and 0 in the last cycle (data hold).
- Read: sram_oe_d = 0 and sram_be = 4'hF.

Completion:
- sram_rdata is registered on the edge that ends the last ACC cycle.
- In DONE, for a CPU access: cpu_ack = 1, and cpu_rdata is valid on a read.
- In DONE, for a video access: vid_valid = 1 and vid_data is valid.

Reset, including mid-access:
- State goes to IDLE. vid_pend = 0, vid_ovf = 0, cpu_ack = 0, vid_valid = 0, sram_we = 0, sram_oe_d = 0.
- sram_adr, sram_be, cpu_rdata and vid_data go to 0.
- An aborted access produces no ack or valid.

## Timing
- Cycle numbering: request sampled in cycle t while the block is in IDLE. Access cycles are t+1..t+ACC_CYC. Ack or valid is in cycle t+ACC_CYC+1.
- Back-to-back accesses: the next access starts at t+ACC_CYC+2. Throughput is one access per ACC_CYC+1 cycles.
- Worst-case refill latency, from vid_req to vid_valid: 2·(ACC_CYC+1) cycles. This covers one in-flight CPU access plus the video access.
- CPU starvation is bounded because refill requests arrive at most once per 32 cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package vid_pkg holds:
  - ADR_W, DATA_W, ACC_CYC defaults.
  - The state enum (IDLE, ACC, DONE).
  - An owner encoding (OWN_CPU, OWN_VID).
- No sub-module. The access counter and the pending register are inline.

## Test plan
All scenarios use ACC_CYC = 2.
- Reset: after rst is released, every output is 0 and the state is IDLE. Asserting rst during ACC of a write drops sram_we to 0 on the next edge, and no cpu_ack follows.
- CPU read: cpu_adr=0x00100, sram_rdata=0xDEADBEEF. Expect sram_adr=0x00100 in t+1..t+2, cpu_ack=1 and cpu_rdata=0xDEADBEEF at t+3, and no regrant at t+3.
- CPU write: cpu_adr=0x3FFFF, cpu_wdata=0x12345678, cpu_be=4'b0011. Expect sram_we=1 only at t+1, sram_oe_d=1 at t+1..t+2, sram_be=4'b0011, and cpu_ack at t+3.
- Simultaneous requests: vid_req (vid_adr=0x38000) and cpu_req arrive together at t. Expect the video access at t+1..t+2, vid_valid at t+3, the CPU access at t+4..t+5, and cpu_ack at t+6.
- Refill during a CPU access: vid_req arrives at t+1 of a CPU read. Expect vid_pend=1, cpu_ack at t+3, the video access at t+4..t+5, and vid_valid at t+6.
- Overrun: two vid_req pulses while vid_pend = 1. Expect vid_ovf to stay 1 until rst, and the second address to be fetched.

Source files
------------

// File: rtl/vid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vid_pkg
//  Description : Shared defaults and encodings for the video/main SRAM arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package vid_pkg;

   localparam int VID_ADR_W   = 18;
   localparam int VID_DATA_W  = 32;
   localparam int VID_ACC_CYC = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic [0:0] {
      OWN_CPU = 1'b0,
      OWN_VID = 1'b1
   } owner_e;

endpackage
`default_nettype wire

// File: rtl/vid_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vid_mem_arbiter
//  Description : Single-port SRAM arbiter; display refill has priority over CPU.
//  Revision    : 1.0 - initial release
// ============================================================================
module vid_mem_arbiter
   import vid_pkg::*;
#(
   parameter int ADR_W   = VID_ADR_W,
   parameter int DATA_W  = VID_DATA_W,
   parameter int ACC_CYC = VID_ACC_CYC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADR_W-1:0]  cpu_adr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic [3:0]        cpu_be,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              vid_req,
   input  logic [ADR_W-1:0]  vid_adr,
   output logic              vid_valid,
   output logic [DATA_W-1:0] vid_data,
   output logic              vid_ovf,
   output logic [ADR_W-1:0]  sram_adr,
   output logic [DATA_W-1:0] sram_wdata,
   output logic              sram_oe_d,
   output logic              sram_we,
   output logic [3:0]        sram_be,
   input  logic [DATA_W-1:0] sram_rdata
);

   localparam int               CNT_W  = $clog2(ACC_CYC);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(ACC_CYC - 1);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic              wr_q, wr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              pend_q, pend_d;
   logic [ADR_W-1:0]  pend_adr_q, pend_adr_d;
   logic              ovf_q, ovf_d;
   logic [ADR_W-1:0]  adr_q, adr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        be_q, be_d;
   logic              oe_q, oe_d;
   logic              we_q, we_d;
   logic              ack_q, ack_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic              vvalid_q, vvalid_d;
   logic [DATA_W-1:0] vid_data_q, vid_data_d;
   logic              grant_vid, grant_cpu;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_CPU;
         wr_q        <= 1'b0;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
         pend_adr_q  <= '0;
         ovf_q       <= 1'b0;
         adr_q       <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         oe_q        <= 1'b0;
         we_q        <= 1'b0;
         ack_q       <= 1'b0;
         cpu_rdata_q <= '0;
         vvalid_q    <= 1'b0;
         vid_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         wr_q        <= wr_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         pend_adr_q  <= pend_adr_d;
         ovf_q       <= ovf_d;
         adr_q       <= adr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         oe_q        <= oe_d;
         we_q        <= we_d;
         ack_q       <= ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         vvalid_q    <= vvalid_d;
         vid_data_q  <= vid_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      wr_d        = wr_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      pend_adr_d  = pend_adr_q;
      ovf_d       = ovf_q | (vid_req & pend_q);
      adr_d       = adr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      oe_d        = oe_q;
      we_d        = we_q;
      ack_d       = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      vvalid_d    = 1'b0;
      vid_data_d  = vid_data_q;
      grant_vid   = 1'b0;
      grant_cpu   = 1'b0;

      // A refill not granted this cycle is parked; a newer one overwrites it.
      if (vid_req) begin
         pend_d     = 1'b1;
         pend_adr_d = vid_adr;
      end

      case (state_q)
         ST_IDLE, ST_DONE: begin
            grant_vid = vid_req | pend_q;
            // The DONE cycle of a CPU access still sees the old cpu_req level.
            grant_cpu = !grant_vid && cpu_req &&
                        !(state_q == ST_DONE && owner_q == OWN_CPU);
            oe_d = 1'b0;
            we_d = 1'b0;
            if (grant_vid) begin
               pend_d  = 1'b0;
               state_d = ST_ACC;
               owner_d = OWN_VID;
               wr_d    = 1'b0;
               cnt_d   = '0;
               adr_d   = vid_req ? vid_adr : pend_adr_q;
               be_d    = 4'hF;
            end else if (grant_cpu) begin
               state_d = ST_ACC;
               owner_d = OWN_CPU;
               wr_d    = cpu_we;
               cnt_d   = '0;
               adr_d   = cpu_adr;
               be_d    = cpu_we ? cpu_be : 4'hF;
               wdata_d = cpu_wdata;
               oe_d    = cpu_we;
               we_d    = cpu_we;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACC: begin
            if (cnt_q == C_LAST) begin
               state_d = ST_DONE;
               oe_d    = 1'b0;
               we_d    = 1'b0;
               if (owner_q == OWN_CPU) begin
                  ack_d = 1'b1;
                  if (!wr_q) cpu_rdata_d = sram_rdata;
               end else begin
                  vvalid_d   = 1'b1;
                  vid_data_d = sram_rdata;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
               // Strobe drops for the final cycle to give the SRAM data hold.
               we_d  = wr_q && ((int'(cnt_q) + 1) < (ACC_CYC - 1));
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cpu_ack    = ack_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign vid_valid  = vvalid_q;
   assign vid_data   = vid_data_q;
   assign vid_ovf    = ovf_q;
   assign sram_adr   = adr_q;
   assign sram_wdata = wdata_q;
   assign sram_oe_d  = oe_q;
   assign sram_we    = we_q;
   assign sram_be    = be_q;

endmodule
`default_nettype wire

// File: tb/tb_vid_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vid_mem_arbiter
//  Description : Scoreboard bench for vid_mem_arbiter with ACC_CYC = 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vid_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [17:0] cpu_adr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [3:0]  cpu_be = '0;
   logic        cpu_ack;
   logic [31:0] cpu_rdata;
   logic        vid_req = 1'b0;
   logic [17:0] vid_adr = '0;
   logic        vid_valid;
   logic [31:0] vid_data;
   logic        vid_ovf;
   logic [17:0] sram_adr;
   logic [31:0] sram_wdata;
   logic        sram_oe_d, sram_we;
   logic [3:0]  sram_be;
   logic [31:0] sram_rdata;

   typedef struct {
      int          cyc;
      logic [17:0] adr;
      logic        we;
      logic        oe;
      logic [3:0]  be;
      logic [31:0] wdata;
      bit          chkw;
   } snap_t;

   typedef struct {
      int          cyc;
      logic [31:0] data;
      bit          chkd;
   } resp_t;

   snap_t sq[$];
   resp_t cq[$];
   resp_t vq[$];

   int cyc    = 0;
   int n_cmp  = 0;
   int n_bad  = 0;
   int t;

   vid_mem_arbiter #(.ADR_W(18), .DATA_W(32), .ACC_CYC(2)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
      .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .vid_req(vid_req), .vid_adr(vid_adr),
      .vid_valid(vid_valid), .vid_data(vid_data), .vid_ovf(vid_ovf),
      .sram_adr(sram_adr), .sram_wdata(sram_wdata), .sram_oe_d(sram_oe_d),
      .sram_we(sram_we), .sram_be(sram_be), .sram_rdata(sram_rdata)
   );

   function automatic logic [31:0] mem_word(input logic [17:0] a);
      if (a == 18'h00100) return 32'hDEADBEEF;
      return 32'hA5000000 ^ {14'd0, a};
   endfunction

   assign sram_rdata = mem_word(sram_adr);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_acc(input int c0, input logic [17:0] a, input logic wr,
                          input logic [3:0] be, input logic [31:0] wd);
      // Two access cycles: strobe only in the first one for writes.
      sq.push_back('{c0,     a, wr,   wr, wr ? be : 4'hF, wd, wr});
      sq.push_back('{c0 + 1, a, 1'b0, wr, wr ? be : 4'hF, wd, wr});
   endtask

   task automatic cpu_start(input logic w, input logic [17:0] a,
                            input logic [31:0] wd, input logic [3:0] be);
      cpu_req = 1'b1; cpu_we = w; cpu_adr = a; cpu_wdata = wd; cpu_be = be;
   endtask

   // Monitor: pops expectations when the DUT presents the corresponding cycle or pulse.
   always @(negedge clk) begin : mon
      snap_t s;
      resp_t r;
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
         s = sq.pop_front();
         chk($sformatf("sram_adr@%0d", s.cyc), sram_adr, s.adr);
         chk($sformatf("sram_we@%0d", s.cyc), sram_we, s.we);
         chk($sformatf("sram_oe_d@%0d", s.cyc), sram_oe_d, s.oe);
         chk($sformatf("sram_be@%0d", s.cyc), sram_be, s.be);
         if (s.chkw) chk($sformatf("sram_wdata@%0d", s.cyc), sram_wdata, s.wdata);
      end
      if (cq.size() > 0 && cq[0].cyc < cyc) begin
         r = cq.pop_front();
         chk($sformatf("cpu_ack_missing@%0d", r.cyc), 1'b0, 1'b1);
      end
      if (vq.size() > 0 && vq[0].cyc < cyc) begin
         r = vq.pop_front();
         chk($sformatf("vid_valid_missing@%0d", r.cyc), 1'b0, 1'b1);
      end
      if (cpu_ack) begin
         if (cq.size() == 0) chk("cpu_ack_unexpected", cpu_ack, 1'b0);
         else begin
            r = cq.pop_front();
            chk("cpu_ack_cycle", 64'(cyc), 64'(r.cyc));
            if (r.chkd) chk("cpu_rdata", cpu_rdata, r.data);
         end
      end
      if (vid_valid) begin
         if (vq.size() == 0) chk("vid_valid_unexpected", vid_valid, 1'b0);
         else begin
            r = vq.pop_front();
            chk("vid_valid_cycle", 64'(cyc), 64'(r.cyc));
            chk("vid_data", vid_data, r.data);
         end
      end
   end

   initial begin
      // Reset state
      repeat (3) tick();
      rst = 1'b0;
      tick(); tick();
      chk("rst_cpu_ack", cpu_ack, 1'b0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      chk("rst_vid_valid", vid_valid, 1'b0);
      chk("rst_vid_data", vid_data, 32'd0);
      chk("rst_vid_ovf", vid_ovf, 1'b0);
      chk("rst_sram_adr", sram_adr, 18'd0);
      chk("rst_sram_oe_d", sram_oe_d, 1'b0);
      chk("rst_sram_we", sram_we, 1'b0);
      chk("rst_sram_be", sram_be, 4'd0);

      // CPU read; req stays high through the ack cycle to expose a regrant
      tick(); t = cyc;
      cpu_start(1'b0, 18'h00100, 32'd0, 4'hF);
      exp_acc(t + 1, 18'h00100, 1'b0, 4'hF, 32'd0);
      cq.push_back('{t + 3, 32'hDEADBEEF, 1'b1});
      repeat (4) tick();
      cpu_req = 1'b0;
      repeat (3) tick();

      // CPU write at the top address
      t = cyc;
      cpu_start(1'b1, 18'h3FFFF, 32'h12345678, 4'b0011);
      exp_acc(t + 1, 18'h3FFFF, 1'b1, 4'b0011, 32'h12345678);
      cq.push_back('{t + 3, 32'd0, 1'b0});
      repeat (4) tick();
      cpu_req = 1'b0;
      repeat (3) tick();

      // Simultaneous video and CPU requests: video first
      t = cyc;
      cpu_start(1'b0, 18'h00200, 32'd0, 4'hF);
      vid_req = 1'b1; vid_adr = 18'h38000;
      exp_acc(t + 1, 18'h38000, 1'b0, 4'hF, 32'd0);
      vq.push_back('{t + 3, mem_word(18'h38000), 1'b1});
      exp_acc(t + 4, 18'h00200, 1'b0, 4'hF, 32'd0);
      cq.push_back('{t + 6, mem_word(18'h00200), 1'b1});
      tick();
      vid_req = 1'b0;
      repeat (6) tick();
      cpu_req = 1'b0;
      repeat (3) tick();

      // Refill arriving during a CPU read waits as pending
      t = cyc;
      cpu_start(1'b0, 18'h00300, 32'd0, 4'hF);
      exp_acc(t + 1, 18'h00300, 1'b0, 4'hF, 32'd0);
      cq.push_back('{t + 3, mem_word(18'h00300), 1'b1});
      exp_acc(t + 4, 18'h01000, 1'b0, 4'hF, 32'd0);
      vq.push_back('{t + 6, mem_word(18'h01000), 1'b1});
      tick();
      vid_req = 1'b1; vid_adr = 18'h01000;
      tick();
      vid_req = 1'b0;
      repeat (2) tick();
      cpu_req = 1'b0;
      repeat (5) tick();
      chk("ovf_after_single_pend", vid_ovf, 1'b0);

      // Overrun: second refill while one is pending replaces it and sets the flag
      t = cyc;
      cpu_start(1'b0, 18'h00400, 32'd0, 4'hF);
      exp_acc(t + 1, 18'h00400, 1'b0, 4'hF, 32'd0);
      cq.push_back('{t + 3, mem_word(18'h00400), 1'b1});
      exp_acc(t + 4, 18'h02040, 1'b0, 4'hF, 32'd0);
      vq.push_back('{t + 6, mem_word(18'h02040), 1'b1});
      tick();
      vid_req = 1'b1; vid_adr = 18'h02000;
      tick();
      chk("ovf_before_overrun", vid_ovf, 1'b0);
      vid_adr = 18'h02040;
      tick();
      vid_req = 1'b0;
      chk("ovf_set", vid_ovf, 1'b1);
      tick();
      cpu_req = 1'b0;
      repeat (8) tick();
      chk("ovf_sticky", vid_ovf, 1'b1);

      // Reset in the middle of a write: strobe drops, no ack
      t = cyc;
      cpu_start(1'b1, 18'h00500, 32'hAAAA5555, 4'hF);
      sq.push_back('{t + 1, 18'h00500, 1'b1, 1'b1, 4'hF, 32'hAAAA5555, 1'b1});
      tick();
      rst = 1'b1; cpu_req = 1'b0;
      tick();
      chk("midrst_sram_we", sram_we, 1'b0);
      chk("midrst_sram_oe_d", sram_oe_d, 1'b0);
      chk("midrst_sram_adr", sram_adr, 18'd0);
      chk("midrst_vid_ovf", vid_ovf, 1'b0);
      rst = 1'b0;
      repeat (8) tick();

      chk("pending_sram_expect", 64'(sq.size()), 64'd0);
      chk("pending_cpu_ack", 64'(cq.size()), 64'd0);
      chk("pending_vid_valid", 64'(vq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
